// File: rtl/barret_pipe_red_pkg.sv
// Shared Barrett helpers: derived width K, reduction constant MU and the
// modulus legality check used at elaboration.
package barret_pkg;

  function automatic int barret_k(input longint q);
    return $clog2(q);
  endfunction

  function automatic longint barret_mu(input longint q);
    return (64'sd1 <<< (2 * barret_k(q))) / q;
  endfunction

  // A power of two has exactly one bit set, so q & (q-1) is zero for it.
  function automatic bit barret_q_ok(input longint q);
    return (q >= 64'sd3) && ((q & (q - 64'sd1)) != 64'sd0);
  endfunction

endpackage

// File: rtl/barret_pipe_red_csub.sv
// Final Barrett correction: r0 < 4Q, so subtract the largest of 0/Q/2Q/3Q
// that does not exceed r0. Purely combinational.
module barret_csub
  import barret_pkg::*;
#(
  parameter int Q = 421,
  parameter int K = 9
) (
  input  logic [K+1:0] i_r0,
  output logic [K-1:0] o_r
);

  localparam logic [K+1:0] L_Q1 = (K+2)'(Q);
  localparam logic [K+1:0] L_Q2 = (K+2)'(2 * Q);
  localparam logic [K+1:0] L_Q3 = (K+2)'(3 * Q);

  logic         w_ge1;
  logic         w_ge2;
  logic         w_ge3;
  logic [K+1:0] w_sel;
  logic         w_unused_hi;

  assign w_ge1 = (i_r0 >= L_Q1);
  assign w_ge2 = (i_r0 >= L_Q2);
  assign w_ge3 = (i_r0 >= L_Q3);

  // Thermometer-coded compares select the multiple of Q to remove.
  always_comb begin
    w_sel = i_r0;
    case ({w_ge3, w_ge2, w_ge1})
      3'b111:  w_sel = i_r0 - L_Q3;
      3'b011:  w_sel = i_r0 - L_Q2;
      3'b001:  w_sel = i_r0 - L_Q1;
      3'b000:  w_sel = i_r0;
      default: w_sel = i_r0;
    endcase
  end

  assign o_r         = w_sel[K-1:0];
  assign w_unused_hi = |w_sel[K+1:K];

endmodule

// File: rtl/barret_pipe_red.sv
// Three-stage pipelined Barrett reducer (o_r = i_a mod Q) with valid/ready
// backpressure. Defining BARRETT_TAG_EN adds a sideband tag pipeline.
module barret_pipe_red
  import barret_pkg::*;
#(
  parameter  int Q     = 421,
  parameter  int TAG_W = 8,
  localparam int K     = barret_k(Q),
  localparam int IN_W  = 2 * K,
  localparam int MU    = int'(barret_mu(Q))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [IN_W-1:0]  i_a,
`ifdef BARRETT_TAG_EN
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag,
`endif
  output logic             o_valid,
  input  logic             o_ready,
  output logic [K-1:0]     o_r
);

  localparam logic [K:0]   L_MU = (K+1)'(MU);
  localparam logic [K-1:0] L_Q  = K'(Q);

  generate
    if (!barret_q_ok(Q)) begin : g_bad_q
      $error("barret_pipe_red: Q must be >= 3 and not a power of two");
    end
  endgenerate

  logic            w_adv;
  logic [K-1:0]    w_q1;
  logic [2*K:0]    w_p;
  logic [K:0]      w_t;
  logic [2*K:0]    w_m;
  logic [2*K:0]    w_diff;
  logic [K+1:0]    w_r0;
  logic [K-1:0]    w_r_red;
  logic            w_unused;

  logic            r_s1_vld;
  logic            r_s2_vld;
  logic            r_o_valid;
  logic [2*K:0]    r_s1_p;
  logic [2*K:0]    r_s2_m;
  logic [IN_W-1:0] r_s1_a;
  logic [IN_W-1:0] r_s2_a;
  logic [K-1:0]    r_o_r;

  assign w_adv   = ~r_o_valid | o_ready;
  assign i_ready = w_adv;
  assign o_valid = r_o_valid;
  assign o_r     = r_o_r;

  assign w_q1   = i_a[IN_W-1:K];
  assign w_p    = {{(K+1){1'b0}}, w_q1} * {{K{1'b0}}, L_MU};
  assign w_t    = r_s1_p[2*K:K];
  assign w_m    = {{K{1'b0}}, w_t} * {{(K+1){1'b0}}, L_Q};
  // Only the low K+2 bits of a - m matter: the true remainder is below 4Q.
  assign w_diff = {1'b0, r_s2_a} - r_s2_m;
  assign w_r0   = w_diff[K+1:0];
  assign w_unused = ^{r_s1_p[K-1:0], w_diff[2*K:K+2]};

  barret_csub #(
    .Q (Q),
    .K (K)
  ) u_csub (
    .i_r0 (w_r0),
    .o_r  (w_r_red)
  );

  // Stage valid bits shift together on advance; a bubble enters as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_o_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld  <= i_valid;
      r_s2_vld  <= r_s1_vld;
      r_o_valid <= r_s2_vld;
    end
  end

  // Datapath registers load on every advance and hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_p <= '0;
      r_s1_a <= '0;
      r_s2_m <= '0;
      r_s2_a <= '0;
      r_o_r  <= '0;
    end else if (w_adv) begin
      r_s1_p <= w_p;
      r_s1_a <= i_a;
      r_s2_m <= w_m;
      r_s2_a <= r_s1_a;
      r_o_r  <= w_r_red;
    end
  end

`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0] r_s1_tag;
  logic [TAG_W-1:0] r_s2_tag;
  logic [TAG_W-1:0] r_o_tag;

  // Tag travels with its word under the same advance/stall control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_tag <= '0;
      r_s2_tag <= '0;
      r_o_tag  <= '0;
    end else if (w_adv) begin
      r_s1_tag <= i_tag;
      r_s2_tag <= r_s1_tag;
      r_o_tag  <= r_s2_tag;
    end
  end

  assign o_tag = r_o_tag;
`else
  logic [TAG_W-1:0] w_unused_tag;
  assign w_unused_tag = {TAG_W{1'b0}};
`endif

endmodule

// File: tb/tb_barret_pipe_red.sv
// Directed bench for barret_pipe_red: Q=421 and Q=3329 instances, table
// vectors plus backpressure, bubble, mid-stream reset and random streams.
module tb_barret_pipe_red;

  localparam int QA  = 421;
  localparam int KA  = 9;
  localparam int INA = 18;
  localparam int QB  = 3329;
  localparam int KB  = 12;
  localparam int INB = 24;

  typedef struct {
    logic [23:0] a;
    logic [15:0] r;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           o_ready;
  logic           i_valid_a, i_ready_a, o_valid_a;
  logic [INA-1:0] i_a_a;
  logic [KA-1:0]  o_r_a;
  logic           i_valid_b, i_ready_b, o_valid_b;
  logic [INB-1:0] i_a_b;
  logic [KB-1:0]  o_r_b;
`ifdef BARRETT_TAG_EN
  logic [7:0]     i_tag_a, o_tag_a, i_tag_b, o_tag_b, last_tag_a, tag_cnt;
  int             qt_a[$];
`endif

  int             n_vec = 0;
  int             n_bad = 0;
  int             n_out_a = 0;
  int             q_a[$];
  int             q_b[$];
  bit             stall_a, stall_b;
  logic [KA-1:0]  last_r_a;
  logic [KB-1:0]  last_r_b;
  vec_t           tv_a[5];
  vec_t           tv_b[3];
  logic [INA-1:0] bp_w[5];

  always #5 clk = ~clk;

  barret_pipe_red #(.Q(QA), .TAG_W(8)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid_a),
    .i_ready (i_ready_a),
    .i_a     (i_a_a),
`ifdef BARRETT_TAG_EN
    .i_tag   (i_tag_a),
    .o_tag   (o_tag_a),
`endif
    .o_valid (o_valid_a),
    .o_ready (o_ready),
    .o_r     (o_r_a)
  );

  barret_pipe_red #(.Q(QB), .TAG_W(8)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid_b),
    .i_ready (i_ready_b),
    .i_a     (i_a_b),
`ifdef BARRETT_TAG_EN
    .i_tag   (i_tag_b),
    .o_tag   (o_tag_b),
`endif
    .o_valid (o_valid_b),
    .o_ready (o_ready),
    .o_r     (o_r_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check held outputs, drive inputs, score the coming transfers.
  task automatic cycle(input bit va, input logic [INA-1:0] aa, input bit vb,
                       input logic [INB-1:0] ab, input bit rdy);
    @(negedge clk);
    if (stall_a) begin
      check("hold_valid_a", o_valid_a, 32'd1);
      check("hold_r_a", o_r_a, last_r_a);
`ifdef BARRETT_TAG_EN
      check("hold_tag_a", o_tag_a, last_tag_a);
`endif
    end
    if (stall_b) begin
      check("hold_valid_b", o_valid_b, 32'd1);
      check("hold_r_b", o_r_b, last_r_b);
    end
    i_valid_a = va;
    i_a_a     = aa;
    i_valid_b = vb;
    i_a_b     = ab;
    o_ready   = rdy;
`ifdef BARRETT_TAG_EN
    i_tag_a = tag_cnt;
    tag_cnt = tag_cnt + 8'd1;
`endif
    #1;
    check("ready_a", i_ready_a, (!o_valid_a || o_ready) ? 32'd1 : 32'd0);
    check("ready_b", i_ready_b, (!o_valid_b || o_ready) ? 32'd1 : 32'd0);
    if (i_valid_a && i_ready_a) begin
      q_a.push_back(int'(aa % QA));
`ifdef BARRETT_TAG_EN
      qt_a.push_back(int'(i_tag_a));
`endif
    end
    if (i_valid_b && i_ready_b) q_b.push_back(int'(ab % QB));
    if (o_valid_a && o_ready) begin
      n_out_a++;
      check("expected_out_a", (q_a.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (q_a.size() != 0) check("data_a", o_r_a, q_a.pop_front());
`ifdef BARRETT_TAG_EN
      if (qt_a.size() != 0) check("tag_a", o_tag_a, qt_a.pop_front());
`endif
    end
    if (o_valid_b && o_ready) begin
      check("expected_out_b", (q_b.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (q_b.size() != 0) check("data_b", o_r_b, q_b.pop_front());
    end
    stall_a  = o_valid_a && !o_ready;
    stall_b  = o_valid_b && !o_ready;
    last_r_a = o_r_a;
    last_r_b = o_r_b;
`ifdef BARRETT_TAG_EN
    last_tag_a = o_tag_a;
`endif
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++)
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check({nm, "_drain_a"}, q_a.size(), 32'd0);
    check({nm, "_drain_b"}, q_b.size(), 32'd0);
  endtask

  initial begin
    int w;
    bit pv[12];
    bit exp_v;

    tv_a[0] = '{24'd0,      16'd0};
    tv_a[1] = '{24'd420,    16'd420};
    tv_a[2] = '{24'd421,    16'd0};
    tv_a[3] = '{24'd131071, 16'd140};
    tv_a[4] = '{24'd262143, 16'd281};
    tv_b[0] = '{24'd11075584, 16'd1};
    tv_b[1] = '{24'd11082241, 16'd0};
    tv_b[2] = '{24'd16777215, 16'd2384};
    bp_w[0] = 18'd1000;
    bp_w[1] = 18'd262000;
    bp_w[2] = 18'd126300;
    bp_w[3] = 18'd5;
    bp_w[4] = 18'd842;

    rst_n = 1'b1; o_ready = 1'b1;
    i_valid_a = 1'b0; i_a_a = '0; i_valid_b = 1'b0; i_a_b = '0;
    stall_a = 1'b0; stall_b = 1'b0; last_r_a = '0; last_r_b = '0;
`ifdef BARRETT_TAG_EN
    i_tag_a = 8'd0; i_tag_b = 8'd0; tag_cnt = 8'd1; last_tag_a = 8'd0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_a", o_valid_a, 32'd0);
    check("rst_r_a", o_r_a, 32'd0);
    check("rst_ready_a", i_ready_a, 32'd1);
    check("rst_valid_b", o_valid_b, 32'd0);
    check("rst_r_b", o_r_b, 32'd0);
`ifdef BARRETT_TAG_EN
    check("rst_tag_a", o_tag_a, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: each result exactly 3 cycles after its input, back-to-back.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        check("tbl_valid_a", o_valid_a, 32'd1);
        check("tbl_r_a", o_r_a, tv_a[c-3].r);
      end else check("tbl_idle_a", o_valid_a, 32'd0);
      if (c >= 3 && c < 6) begin
        check("tbl_valid_b", o_valid_b, 32'd1);
        check("tbl_r_b", o_r_b, tv_b[c-3].r);
      end else check("tbl_idle_b", o_valid_b, 32'd0);
      check("tbl_ready_a", i_ready_a, 32'd1);
      i_valid_a = (c < 5) ? 1'b1 : 1'b0;
      if (c < 5) i_a_a = tv_a[c].a[INA-1:0];
      else i_a_a = '0;
      i_valid_b = (c < 3) ? 1'b1 : 1'b0;
      if (c < 3) i_a_b = tv_b[c].a[INB-1:0];
      else i_a_b = '0;
    end

    // Backpressure: 5 words offered continuously, o_ready low for cycles 4..8.
    n_out_a = 0;
    w = 0;
    for (int c = 0; c < 30 && (w < 5 || q_a.size() != 0); c++) begin
      cycle((w < 5), (w < 5) ? bp_w[w] : '0, 1'b0, '0, !(c >= 4 && c <= 8));
      if (c >= 4 && c <= 8) check("bp_ready_low", i_ready_a, 32'd0);
      if (i_valid_a && i_ready_a) w++;
    end
    check("bp_fed", w, 32'd5);
    check("bp_out_count", n_out_a, 32'd5);
    drain("bp");

    // Bubbles: o_valid repeats the i_valid pattern three cycles later.
    for (int c = 0; c < 12; c++) begin
      pv[c] = (c < 8) && (c % 2 == 0);
      cycle(pv[c], INA'(c * 1000 + 7), 1'b0, '0, 1'b1);
      exp_v = 1'b0;
      if (c >= 3) exp_v = pv[c-3];
      check("bub_valid_a", o_valid_a, exp_v);
    end
    drain("bub");

    // Reset with three words in flight discards them.
    for (int c = 0; c < 3; c++)
      cycle(1'b1, INA'(c * 5000 + 123), 1'b1, INB'(c * 70000 + 9), 1'b1);
    @(negedge clk);
    check("pre_rst_valid_a", o_valid_a, 32'd1);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", o_valid_a, 32'd0);
    check("mid_rst_r_a", o_r_a, 32'd0);
    check("mid_rst_valid_b", o_valid_b, 32'd0);
    check("mid_rst_r_b", o_r_b, 32'd0);
    q_a.delete();
    q_b.delete();
`ifdef BARRETT_TAG_EN
    qt_a.delete();
`endif
    stall_a = 1'b0;
    stall_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
      check("post_rst_idle_a", o_valid_a, 32'd0);
      check("post_rst_idle_b", o_valid_b, 32'd0);
      check("post_rst_ready_a", i_ready_a, 32'd1);
    end

    // Random stream with random backpressure against a % Q scoreboards.
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(3) != 0, INA'($urandom), $urandom_range(3) != 0,
            INB'($urandom), $urandom_range(9) < 7);
    drain("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
